display_arbiter: RTL



---
 rtl/display_pkg.sv | 23 ++
 rtl/display_arbiter_rr_pick.sv | 52 +++++
 rtl/display_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display arbiter slice.
//   BCD_MAX   : largest value the 4-digit seven-segment display can show
//   OWNER_W   : width of a requester index (supports up to 8 requesters)
//   state_t   : arbiter FSM states (IDLE, SHOW)
//   clamp_bcd : saturates a binary value to the 4-digit display range
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int BCD_MAX = 9999;
  localparam int OWNER_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  function automatic logic [31:0] clamp_bcd(input logic [31:0] v);
    return (v > 32'(BCD_MAX)) ? 32'(BCD_MAX) : v;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// start_in and wrapping around; the first set bit wins.
//   req_in   [NUM_REQ] : request vector
//   start_in [OWNER_W] : index where the scan begins (must be < NUM_REQ)
//   win_out  [NUM_REQ] : one-hot winner (all zero when nothing requested)
//   any_out  [1]       : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import display_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [OWNER_W-1:0] start_in,
  output logic [NUM_REQ-1:0] win_out,
  output logic               any_out
);

  logic [NUM_REQ-1:0] w_hit;
  logic [NUM_REQ-1:0] w_onehot [NUM_REQ];

  // For each scan offset, work out which physical requester it lands on.
  // start_in < NUM_REQ, so a single conditional subtract does the wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_offset
      logic [OWNER_W:0]   w_sum;
      logic [OWNER_W-1:0] w_idx;
      assign w_sum = {1'b0, start_in} + (OWNER_W + 1)'(gi);
      assign w_idx = (w_sum >= (OWNER_W + 1)'(NUM_REQ))
                   ? OWNER_W'(w_sum - (OWNER_W + 1)'(NUM_REQ))
                   : OWNER_W'(w_sum);
      assign w_onehot[gi] = NUM_REQ'(1) << w_idx;
      assign w_hit[gi]    = |(req_in & w_onehot[gi]);
    end
  endgenerate

  // Lowest scan offset with a request wins.
  always_comb begin
    win_out = '0;
    any_out = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_out && w_hit[i]) begin
        win_out = w_onehot[i];
        any_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Time-multiplexes one 4-digit seven-segment display between NUM_REQ value
// sources. Grants round-robin, holds each granted value for HOLD_CYCLES clocks
// and drives the display driver with the value clamped to 0..9999.
//
// Optional feature macro: DISPLAY_ARB_PREEMPT_EN
//   When defined, requester 0 may cut another owner's dwell short.
//
// Ports
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   req_in    : per-requester level request, held until granted
//   val_in    : requester k's value in bits [32k+31:32k]
//   grant_out : one-cycle one-hot pulse naming the latched requester
//   owner_out : index of the requester currently on display
//   val_out   : clamped value to the display driver
//   valid_out : high once any value has been granted since reset
//   busy_out  : high while a dwell is running (SHOW)
// -----------------------------------------------------------------------------
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_REQ-1:0]    req_in,
  input  logic [32*NUM_REQ-1:0] val_in,
  output logic [NUM_REQ-1:0]    grant_out,
  output logic [OWNER_W-1:0]    owner_out,
  output logic [31:0]           val_out,
  output logic                  valid_out,
  output logic                  busy_out
);

  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQ - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [OWNER_W-1:0] r_last;
  logic [OWNER_W-1:0] r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [31:0]        r_val;
  logic               r_valid;

  logic [OWNER_W-1:0] w_start;
  logic [NUM_REQ-1:0] w_win;
  logic               w_any;
  logic               w_dwell_done;
  logic               w_preempt;
  logic               w_take;
  logic [NUM_REQ-1:0] w_sel;
  logic [OWNER_W-1:0] w_sel_idx;
  logic [31:0]        w_sel_val;
  logic [31:0]        w_slices [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slices[gi] = val_in[32*gi +: 32];
    end
  endgenerate

  // Search begins just after the last owner so a requester that keeps its
  // request up after being served is visited last.
  assign w_start = (r_last == LAST_IDX) ? '0 : r_last + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_in   (req_in),
    .start_in (w_start),
    .win_out  (w_win),
    .any_out  (w_any)
  );

  assign w_dwell_done = (r_cnt == '0);

`ifdef DISPLAY_ARB_PREEMPT_EN
  // Requester 0 jumps the queue mid-dwell, but never re-grants itself.
  assign w_preempt = (r_state == SHOW) && req_in[0] && (r_owner != '0);
`else
  assign w_preempt = 1'b0;
`endif

  assign w_take = w_preempt || (w_any && ((r_state == IDLE) || w_dwell_done));
  assign w_sel  = w_preempt ? NUM_REQ'(1) : w_win;

  // One-hot to index plus value mux for the selected requester.
  always_comb begin
    w_sel_idx = '0;
    w_sel_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel[i]) begin
        w_sel_idx = OWNER_W'(i);
        w_sel_val = w_slices[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= LAST_IDX;
      r_owner <= '0;
      r_grant <= '0;
      r_val   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_grant <= '0;
      if (w_take) begin
        r_state <= SHOW;
        r_cnt   <= CNT_LOAD;
        r_last  <= w_sel_idx;
        r_owner <= w_sel_idx;
        r_grant <= w_sel;
        r_val   <= clamp_bcd(w_sel_val);
        r_valid <= 1'b1;
      end else if (r_state == SHOW) begin
        // Counter parks at zero; leaving SHOW only when nobody is waiting.
        if (w_dwell_done) begin
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign grant_out = r_grant;
  assign owner_out = r_owner;
  assign val_out   = r_val;
  assign valid_out = r_valid;
  assign busy_out  = (r_state == SHOW);

endmodule
